// File: rtl/aes_sbox_arbiter.sv
// -----------------------------------------------------------------------------
// aes_sbox_arbiter
//
// Shares one aes_sbox between the round datapath (SubBytes on a 128-bit
// state) and the key expansion (SubWord on a 32-bit word). One operation is
// in flight at a time: IDLE accepts a request, EVAL drives the shared sbox
// for one cycle and registers its output, RESP holds the result until the
// owning requester takes it.
//
// Parameters
//   RR_EN          1 = round-robin between the two requesters,
//                  0 = fixed priority to the key requester
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   dat_req_*      SubBytes request  (valid/ready/data, 128 bits)
//   dat_rsp_*      SubBytes response (valid/ready/data, 128 bits)
//   key_req_*      SubWord request   (valid/ready/word, 32 bits)
//   key_rsp_*      SubWord response  (valid/ready/word, 32 bits)
//   sb_in          to shared aes_sbox in       (128 bits)
//   sb_key_in      to shared aes_sbox key_in   (32 bits)
//   sb_key_gen     to shared aes_sbox key_gen
//   sb_out         from shared aes_sbox out    (128 bits)
//   sb_key_out     from shared aes_sbox key_out (32 bits)
//   busy           high whenever the state machine is not in IDLE
// -----------------------------------------------------------------------------
package aes_pkg;
  typedef logic [127:0] aes_128;
  typedef logic [31:0]  aes_32;
endpackage

module aes_sbox_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dat_req_valid,
  output logic            dat_req_ready,
  input  aes_pkg::aes_128 dat_req_data,
  output logic            dat_rsp_valid,
  input  logic            dat_rsp_ready,
  output aes_pkg::aes_128 dat_rsp_data,
  input  logic            key_req_valid,
  output logic            key_req_ready,
  input  aes_pkg::aes_32  key_req_word,
  output logic            key_rsp_valid,
  input  logic            key_rsp_ready,
  output aes_pkg::aes_32  key_rsp_word,
  output aes_pkg::aes_128 sb_in,
  output aes_pkg::aes_32  sb_key_in,
  output logic            sb_key_gen,
  input  aes_pkg::aes_128 sb_out,
  input  aes_pkg::aes_32  sb_key_out,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_DAT = 1'b0,
    OWN_KEY = 1'b1
  } owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q;
  owner_e          last_grant_q;
  aes_pkg::aes_128 operand_q;
  aes_pkg::aes_128 result_q;

  logic            grant_dat;
  logic            grant_key;
  logic            in_idle;
  logic            in_eval;
  logic            in_resp;
  logic            req_hs;
  logic            rsp_hs;
  aes_pkg::aes_128 eval_result;

  // Every output is qualified with !rst so that the reset cycle itself shows
  // no ready, valid or sbox activity, even before the state register has
  // seen its first reset edge.
  assign in_idle = !rst && (state_q == ST_IDLE);
  assign in_eval = !rst && (state_q == ST_EVAL);
  assign in_resp = !rst && (state_q == ST_RESP);

  // Grant selection. With both requesters valid, round-robin picks whoever
  // did not win last time; last-grant resets to DAT so KEY wins first.
  // NOTE: every signal assigned in always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_dat = 1'b0;
    grant_key = 1'b0;
    if (dat_req_valid && key_req_valid) begin
      if (RR_EN) begin
        grant_key = (last_grant_q == OWN_DAT);
      end else begin
        grant_key = 1'b1;
      end
      grant_dat = !grant_key;
    end else begin
      grant_dat = dat_req_valid;
      grant_key = key_req_valid;
    end
  end

  assign dat_req_ready = in_idle && grant_dat;
  assign key_req_ready = in_idle && grant_key;

  assign req_hs = (dat_req_valid && dat_req_ready) ||
                  (key_req_valid && key_req_ready);

  assign rsp_hs = in_resp && ((owner_q == OWN_DAT) ? dat_rsp_ready
                                                   : key_rsp_ready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_hs) state_d = ST_EVAL;
      ST_EVAL: state_d = ST_RESP;
      ST_RESP: if (rsp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The shared sbox sees the operand only during EVAL, and only on the port
  // that belongs to the owner; all other times its inputs are held at zero.
  assign sb_key_gen = in_eval && (owner_q == OWN_KEY);
  assign sb_in      = (in_eval && (owner_q == OWN_DAT)) ? operand_q : '0;
  assign sb_key_in  = sb_key_gen ? operand_q[31:0] : '0;

  assign eval_result = (owner_q == OWN_KEY) ? {96'b0, sb_key_out} : sb_out;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // The data registers are reset as well: the response data outputs come
  // straight from result_q and must not show X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_DAT;
      last_grant_q <= OWN_DAT;
      operand_q    <= '0;
      result_q     <= '0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        // A KEY word is zero-extended so the operand register has a single
        // layout; only bits [31:0] reach the sbox for a KEY owner.
        operand_q <= key_req_ready ? {96'b0, key_req_word} : dat_req_data;
        owner_q   <= key_req_ready ? OWN_KEY : OWN_DAT;
      end
      if (state_q == ST_EVAL) begin
        result_q     <= eval_result;
        last_grant_q <= owner_q;
      end
    end
  end

  assign dat_rsp_valid = in_resp && (owner_q == OWN_DAT);
  assign key_rsp_valid = in_resp && (owner_q == OWN_KEY);

  // Data outputs follow the result register directly, so they keep showing
  // the last result after the handshake.
  assign dat_rsp_data = result_q;
  assign key_rsp_word = result_q[31:0];

  assign busy = !rst && (state_q != ST_IDLE);

endmodule
